// File: rtl/circuit1_sweep_checker_pkg.sv
// Shared definitions for the circuit_1 sweep checker.
// Provides the controller state encoding, the vector count, the worst-case
// gate-network delay and the default golden truth table for circuit_1.
package circuit1_chk_pkg;

  typedef enum logic [2:0] {
    IDLE,
    APPLY,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

  localparam int NUM_VECTORS     = 8;
  // nand 4 + xor 2 + and 7 + nor 6 + or 3 gate-delay units
  localparam int CRIT_PATH_DELAY = 22;
  localparam int DEFAULT_SETTLE  = CRIT_PATH_DELAY + 2;

  localparam logic [NUM_VECTORS-1:0] DEFAULT_EXP_MASK = 8'hAB;

endpackage

// File: rtl/circuit1_sweep_checker_if.sv
// Bundle of the control, stimulus, response and result signals between the
// sweep checker and its environment.
//   master : the checker (drives a/b/c and results, reads start/abort/o)
//   slave  : the environment (drives start/abort/o, reads stimulus/results)
interface circuit1_sweep_checker_if;
  import circuit1_chk_pkg::*;

  logic                   start;
  logic                   abort;
  logic                   a;
  logic                   b;
  logic                   c;
  logic                   o;
  logic                   busy;
  logic                   done;
  logic                   pass;
  logic [3:0]             err_count;
  logic [NUM_VECTORS-1:0] fail_vec;
  logic [2:0]             first_fail_idx;
  logic                   fail_valid;

  modport master (
    input  start, abort, o,
    output a, b, c, busy, done, pass, err_count, fail_vec, first_fail_idx,
           fail_valid
  );

  modport slave (
    output start, abort, o,
    input  a, b, c, busy, done, pass, err_count, fail_vec, first_fail_idx,
           fail_valid
  );

endinterface

// File: rtl/circuit1_sweep_checker_settle_timer.sv
// Loadable 8-bit down-counter used to time the settle window.
//   clk, rst : clock, asynchronous active-high reset
//   load_i   : load value_i (has priority over en_i)
//   en_i     : decrement by one, stopping at zero
//   value_i  : load value
//   zero_o   : counter is zero
module settle_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic       en_i,
  input  logic [7:0] value_i,
  output logic       zero_o
);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = value_i;
    end else if (en_i && (cnt_q != 8'd0)) begin
      cnt_d = cnt_q - 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == 8'd0);

endmodule

// File: rtl/circuit1_sweep_checker.sv
// Sweep checker for the three-input gate network circuit_1.
// Drives all 8 {a,b,c} vectors in order, waits SETTLE_CYCLES for the network
// to settle, samples o against EXP_MASK and accumulates the results.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : start/abort control, a/b/c stimulus, o response, and the
//              busy/done/pass/err_count/fail_vec/first_fail_idx/fail_valid
//              results (all registered)
module circuit1_sweep_checker
  import circuit1_chk_pkg::*;
#(
  parameter int                     SETTLE_CYCLES = DEFAULT_SETTLE,  // 1..255
  parameter logic [NUM_VECTORS-1:0] EXP_MASK      = DEFAULT_EXP_MASK
) (
  input  logic                      clk,
  input  logic                      rst,
  circuit1_sweep_checker_if.master  bus
);

  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

  state_t                 state_q, state_d;
  logic [2:0]             idx_q, idx_d;
  logic [2:0]             abc_q, abc_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   pass_q, pass_d;
  logic [3:0]             err_q, err_d;
  logic [NUM_VECTORS-1:0] fvec_q, fvec_d;
  logic [2:0]             ffi_q, ffi_d;
  logic                   fvld_q, fvld_d;

  logic timer_load;
  logic timer_en;
  logic timer_zero;

  settle_timer u_settle_timer (
    .clk     (clk),
    .rst     (rst),
    .load_i  (timer_load),
    .en_i    (timer_en),
    .value_i (SETTLE_LOAD),
    .zero_o  (timer_zero)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    abc_d      = abc_q;
    done_d     = 1'b0;
    pass_d     = pass_q;
    err_d      = err_q;
    fvec_d     = fvec_q;
    ffi_d      = ffi_q;
    fvld_d     = fvld_q;
    timer_load = 1'b0;
    timer_en   = 1'b0;

    case (state_q)
      IDLE: begin
        abc_d = 3'd0;
        if (bus.start && !bus.abort) begin
          err_d   = 4'd0;
          fvec_d  = '0;
          ffi_d   = 3'd0;
          fvld_d  = 1'b0;
          pass_d  = 1'b0;
          idx_d   = 3'd0;
          state_d = APPLY;
        end
      end
      APPLY: begin
        timer_load = 1'b1;
        state_d    = SETTLE;
      end
      SETTLE: begin
        timer_en = 1'b1;
        if (timer_zero) begin
          state_d = SAMPLE;
        end
      end
      SAMPLE: begin
        if (bus.o != EXP_MASK[idx_q]) begin
          fvec_d[idx_q] = 1'b1;
          // At most 8 samples per sweep, so the 4-bit count never wraps.
          err_d = err_q + 4'd1;
          if (!fvld_q) begin
            ffi_d  = idx_q;
            fvld_d = 1'b1;
          end
        end
        if (idx_q == 3'd7) begin
          abc_d   = 3'd0;
          done_d  = 1'b1;
          // Uses err_d so the final vector's result is included.
          pass_d  = (err_d == 4'd0);
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 3'd1;
          abc_d   = idx_q + 3'd1;
          state_d = APPLY;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort discards any sample taken this cycle and keeps partial results.
    if (bus.abort && (state_q inside {APPLY, SETTLE, SAMPLE})) begin
      state_d = IDLE;
      abc_d   = 3'd0;
      done_d  = 1'b0;
      idx_d   = idx_q;
      pass_d  = pass_q;
      err_d   = err_q;
      fvec_d  = fvec_q;
      ffi_d   = ffi_q;
      fvld_d  = fvld_q;
    end

    busy_d = (state_d inside {APPLY, SETTLE, SAMPLE});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 3'd0;
      abc_q   <= 3'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= 4'd0;
      fvec_q  <= '0;
      ffi_q   <= 3'd0;
      fvld_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      abc_q   <= abc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fvec_q  <= fvec_d;
      ffi_q   <= ffi_d;
      fvld_q  <= fvld_d;
    end
  end

  assign bus.a              = abc_q[2];
  assign bus.b              = abc_q[1];
  assign bus.c              = abc_q[0];
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.pass           = pass_q;
  assign bus.err_count      = err_q;
  assign bus.fail_vec       = fvec_q;
  assign bus.first_fail_idx = ffi_q;
  assign bus.fail_valid     = fvld_q;

endmodule

// File: tb/tb_circuit1_sweep_checker.sv
// Bench for circuit1_sweep_checker: a default instance (SETTLE_CYCLES=24)
// against a delayed circuit_1 model or stuck-at outputs, and a second
// instance with SETTLE_CYCLES=1 against a zero-delay model.
module tb_circuit1_sweep_checker;
  import circuit1_chk_pkg::*;

  localparam int LAT0 = 8 * (24 + 2) + 1;  // 209
  localparam int LAT1 = 8 * (1 + 2) + 1;   // 25

  typedef struct packed {
    logic       pass;
    logic [3:0] err;
    logic [7:0] fvec;
    logic [2:0] ffi;
    logic       fvld;
    int         at;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   mode = 0;          // 0: circuit_1 model, 1: stuck-at-0, 2: stuck-at-1
  logic [21:0] dly = '0;   // 22-cycle delay through the gate network
  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  circuit1_sweep_checker_if bus();
  circuit1_sweep_checker_if bus1();

  circuit1_sweep_checker #(.SETTLE_CYCLES(24), .EXP_MASK(8'hAB)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  circuit1_sweep_checker #(.SETTLE_CYCLES(1), .EXP_MASK(8'hAB)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  // circuit_1 truth table: o = nor(a,b) | c  (8'hAB)
  always @(posedge clk) dly <= {dly[20:0], (~(bus.a | bus.b)) | bus.c};
  assign bus.o  = (mode == 0) ? dly[21] : (mode == 2);
  assign bus1.o = (~(bus1.a | bus1.b)) | bus1.c;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endfunction

  // Scoreboard monitors: pop an expectation on every done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.done) begin
      if (q0.size() == 0) begin
        chk("unexpected_done", bus.done, 1'b0);
      end else begin
        e = q0.pop_front();
        chk("done_cycle", cyc, e.at);
        chk("pass", bus.pass, e.pass);
        chk("err_count", bus.err_count, e.err);
        chk("fail_vec", bus.fail_vec, e.fvec);
        chk("first_fail_idx", bus.first_fail_idx, e.ffi);
        chk("fail_valid", bus.fail_valid, e.fvld);
        chk("done_abc", {bus.a, bus.b, bus.c}, 3'd0);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus1.done) begin
      if (q1.size() == 0) begin
        chk("s1_unexpected_done", bus1.done, 1'b0);
      end else begin
        e = q1.pop_front();
        chk("s1_done_cycle", cyc, e.at);
        chk("s1_pass", bus1.pass, e.pass);
        chk("s1_err_count", bus1.err_count, e.err);
        chk("s1_fail_vec", bus1.fail_vec, e.fvec);
        chk("s1_fail_valid", bus1.fail_valid, e.fvld);
      end
    end
  end

  task automatic launch(input bit track, input logic p, input logic [3:0] ec,
                        input logic [7:0] fv, input logic [2:0] ff, input logic fl);
    exp_t e;
    @(negedge clk);
    e.pass = p; e.err = ec; e.fvec = fv; e.ffi = ff; e.fvld = fl;
    e.at = cyc + LAT0;
    if (track) q0.push_back(e);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (q0.size() != 0 || q1.size() != 0) begin
      chk(name, q0.size() + q1.size(), 0);
      q0.delete();
      q1.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_vec(input logic [2:0] v);
    int n = 0;
    while (!(bus.busy && {bus.a, bus.b, bus.c} == v) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) chk("wait_vec_timeout", {bus.a, bus.b, bus.c}, v);
  endtask

  initial begin
    exp_t e1;
    rst = 1'b1;
    bus.start = 1'b0;  bus.abort = 1'b0;
    bus1.start = 1'b0; bus1.abort = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_pass", bus.pass, 1'b0);
    chk("rst_abc", {bus.a, bus.b, bus.c}, 3'd0);
    chk("rst_err", bus.err_count, 4'd0);
    chk("rst_fvec", bus.fail_vec, 8'h00);
    chk("rst_ffi", bus.first_fail_idx, 3'd0);
    chk("rst_fvld", bus.fail_valid, 1'b0);
    rst = 1'b0;

    // SETTLE_CYCLES=1 instance, zero-delay network
    @(negedge clk);
    e1.pass = 1'b1; e1.err = 4'd0; e1.fvec = 8'h00; e1.ffi = 3'd0; e1.fvld = 1'b0;
    e1.at = cyc + LAT1;
    q1.push_back(e1);
    bus1.start = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0;
    drain("s1_done_timeout");

    // Correct network, with extra start pulses mid-sweep
    mode = 0;
    launch(1'b1, 1'b1, 4'd0, 8'h00, 3'd0, 1'b0);
    repeat (50) @(negedge clk);
    bus.start = 1'b1; @(negedge clk); bus.start = 1'b0;
    repeat (70) @(negedge clk);
    bus.start = 1'b1; @(negedge clk); bus.start = 1'b0;
    drain("pass_done_timeout");

    // Stuck-at-0 and stuck-at-1
    mode = 1;
    launch(1'b1, 1'b0, 4'd5, 8'hAB, 3'd0, 1'b1);
    drain("sa0_done_timeout");
    mode = 2;
    launch(1'b1, 1'b0, 4'd3, 8'h54, 3'd2, 1'b1);
    drain("sa1_done_timeout");

    // Abort during vector 3 settle, correct network
    mode = 0;
    repeat (30) @(negedge clk);
    launch(1'b0, 1'b0, 4'd0, 8'h00, 3'd0, 1'b0);
    wait_vec(3'd3);
    repeat (5) @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("abort_busy", bus.busy, 1'b0);
    chk("abort_abc", {bus.a, bus.b, bus.c}, 3'd0);
    chk("abort_err", bus.err_count, 4'd0);
    chk("abort_pass", bus.pass, 1'b0);
    repeat (250) @(negedge clk);
    launch(1'b1, 1'b1, 4'd0, 8'h00, 3'd0, 1'b0);
    drain("post_abort_timeout");

    // Abort with stuck-at-0 keeps partial results (vectors 0,1 failed)
    mode = 1;
    launch(1'b0, 1'b0, 4'd0, 8'h00, 3'd0, 1'b0);
    wait_vec(3'd3);
    repeat (5) @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("abort_part_err", bus.err_count, 4'd2);
    chk("abort_part_fvec", bus.fail_vec, 8'h03);
    chk("abort_part_ffi", bus.first_fail_idx, 3'd0);
    chk("abort_part_fvld", bus.fail_valid, 1'b1);
    repeat (250) @(negedge clk);

    // start and abort together in IDLE
    bus.start = 1'b1; bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.abort = 1'b0;
    chk("start_abort_busy", bus.busy, 1'b0);
    @(negedge clk);
    chk("start_abort_busy2", bus.busy, 1'b0);

    // Async reset during vector 5, stuck-at-0 so results are non-zero
    launch(1'b0, 1'b0, 4'd0, 8'h00, 3'd0, 1'b0);
    wait_vec(3'd5);
    repeat (3) @(negedge clk);
    chk("pre_rst_fvec", bus.fail_vec, 8'h0B);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", bus.busy, 1'b0);
    chk("arst_abc", {bus.a, bus.b, bus.c}, 3'd0);
    chk("arst_fvec", bus.fail_vec, 8'h00);
    chk("arst_err", bus.err_count, 4'd0);
    @(negedge clk);
    rst = 1'b0;
    mode = 0;
    repeat (30) @(negedge clk);
    launch(1'b1, 1'b1, 4'd0, 8'h00, 3'd0, 1'b0);
    drain("post_rst_timeout");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
